// File: rtl/mem_pkg.sv
// Shared definitions for the memory burst master.
//   ADDR_W / DATA_W / LEN_W : memory address, data word and burst-length widths
//   mem_burst_state_e       : burst master FSM states
//   rd_entry_t              : one read-return FIFO entry (data word + last-of-burst flag)
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } mem_burst_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rd_entry_t;
endpackage

// File: rtl/mem_rd_fifo.sv
// Read-return FIFO: synchronous, show-ahead (head is valid whenever empty=0).
//   clk, srst        : clock, synchronous active-high reset (flushes contents)
//   push, push_data  : write one entry; the caller guarantees space
//   pop              : consume the head entry (ignored when empty)
//   head, empty      : current head entry and empty flag
//   count            : occupancy, used by the master for its credit check
module mem_rd_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  rd_entry_t                push_data,
  input  logic                     pop,
  output rd_entry_t                head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  rd_entry_t     store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_en;

  assign empty  = (count == '0);
  assign pop_en = pop && !empty;
  assign head   = store[rd_ptr];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_burst_master.sv
// Burst master: expands burst commands into single-word memory beats.
//   cmd_*   : burst command (valid/ready), we selects write/read, len = beats-1
//   wr_*    : write data stream in (valid/ready)
//   rd_*    : read data stream out (valid/ready), rd_last marks the final word
//   mem_*   : registered memory port; mem_rdata returns READ_LATENCY cycles later
//   busy    : burst in progress or reads still in flight
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int READ_LATENCY  = 1,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

  mem_burst_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic cmd_hs, wr_hs, rd_issue;

  // mem_rd_q marks a read beat on the port this cycle; lat_v_q[i] marks
  // that beat i+1 cycles later, so lat_v_q[READ_LATENCY-1] lines up with mem_rdata.
  logic                    mem_rd_q, mem_rd_last_q;
  logic [READ_LATENCY-1:0] lat_v_q, lat_last_q;

  logic [CW-1:0] inflight, fifo_count;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  rd_entry_t     push_entry, head;
  logic          fifo_empty;

  always_comb begin
    inflight = CW'(mem_rd_q);
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(lat_v_q[i]);
  end

  // A beat still counts as in flight during its push cycle, so the sum never
  // undercounts; pops only free credit from the following cycle.
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < (CW+1)'(RD_FIFO_DEPTH);

  assign cmd_ready = (state_q == IDLE) && !srst;
  assign wr_ready  = (state_q == WRITE);
  assign busy      = (state_q != IDLE) || (inflight != '0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    cmd_hs   = 1'b0;
    wr_hs    = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_hs = cmd_valid && cmd_ready;
        if (cmd_hs) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_hs = wr_valid;
        if (wr_hs) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        rd_issue = credit_ok;
        if (rd_issue) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_rd_q      <= 1'b0;
      mem_rd_last_q <= 1'b0;
      lat_v_q       <= '0;
      lat_last_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      mem_we        <= wr_hs;
      if (wr_hs || rd_issue) mem_addr <= addr_q;
      if (wr_hs) mem_wdata <= wr_data;
      mem_rd_q      <= rd_issue;
      mem_rd_last_q <= rd_issue && (cnt_q == '0);
      lat_v_q[0]    <= mem_rd_q;
      lat_last_q[0] <= mem_rd_last_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        lat_v_q[i]    <= lat_v_q[i-1];
        lat_last_q[i] <= lat_last_q[i-1];
      end
    end
  end

  assign push_entry.data = mem_rdata;
  assign push_entry.last = lat_last_q[READ_LATENCY-1];

  mem_rd_fifo #(.DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .srst      (srst),
    .push      (lat_v_q[READ_LATENCY-1]),
    .push_data (push_entry),
    .pop       (rd_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_empty ? '0 : head.data;
  assign rd_last  = !fifo_empty && head.last;
endmodule
